id_ex_issue: RTL and testbench
==============================

// Module: id_ex_issue
// PURPOSE
//  Decode/execute boundary stage placed directly upstream of the 32-bit ALU.
//  - Registers one decoded instruction and resolves RAW hazards by forwarding or stalling.
//  - Produces the ALU operands A_in and B_in and the 4-bit ALU_Sel.
//  - Carries memory and writeback control bits to EX/MEM over a valid/ready handshake.
// PARAMETERS
//  XLEN     32  datapath width (ALU operand width)
//  REG_AW   5   register index width
//  PC_W     32  program counter width
// PORTS
//  clk              in   1       single clock, rising edge
//  reset            in   1       synchronous, active-high
//  flush            in   1       kill the held instruction (branch taken)
//  in_valid         in   1       decode presents an instruction
//  in_ready         out  1       stage accepts the instruction this cycle
//  in_pc            in   PC_W    instruction PC
//  in_rs1/in_rs2    in   REG_AW  source register indices
//  in_rd            in   REG_AW  destination register index
//  in_rs1_data      in   XLEN    register-file read data, port 1
//  in_rs2_data      in   XLEN    register-file read data, port 2
//  in_imm           in   XLEN    sign-extended immediate
//  in_alu_op        in   2       00 add, 01 equality, 10 R-type, 11 I-type ALU
//  in_funct3        in   3       instruction funct3
//  in_funct7b5      in   1       instruction bit 30
//  in_alu_src       in   1       1 = B_in takes the immediate
//  in_reg_write/in_mem_read/in_mem_write  in 1 each   control bits
//  exmem_rd, memwb_rd               in  REG_AW  downstream destination indices
//  exmem_reg_write, memwb_reg_write in  1       downstream write enables
//  exmem_mem_read                   in  1       EX/MEM holds a load
//  exmem_result, memwb_result       in  XLEN    forwarding data sources
//  out_valid   out  1      operands valid for the ALU
//  out_ready   in   1      EX/MEM accepts
//  A_in, B_in  out  XLEN   ALU operands
//  ALU_Sel     out  4      ALU operation select
//  store_data  out  XLEN   forwarded rs2 value
//  out_pc, out_rd, out_reg_write, out_mem_read, out_mem_write  out  registered copies
// BEHAVIOUR
//  - Reset: valid_q=0 and every registered field is 0.
//    Outputs after reset: out_valid=0, A_in=0, B_in=0, ALU_Sel=4'b0010, store_data=0, control bits=0.
//  - hazard = valid_q & exmem_mem_read & exmem_rd!=0 & (exmem_rd==rs1_q | exmem_rd==rs2_q).
//  - Handshake:
//    - out_valid = valid_q & ~hazard.
//    - in_ready = ~valid_q | (out_ready & ~hazard).
//    - Capture on in_valid & in_ready.
//    - On out_valid & out_ready with no capture, valid_q clears.
//  - flush is highest priority after reset: valid_q=0 next cycle and the input is not captured that cycle.
//  - Latency: 1 cycle from capture to out_valid when there is no hazard. Full throughput: one instruction per cycle.
//  - Forwarding is combinational from the registered rs indices, so it tracks the downstream stages while this stage is stalled.
//    - EX/MEM match has priority over MEM/WB match.
//    - Register index 0 is never forwarded and always reads the register-file value.
//  - A_in = fwd(rs1). store_data = fwd(rs2). B_in = alu_src_q ? imm_q : fwd(rs2).
//  - ALU_Sel decode:
//    - alu_op 00 -> 0010 (add).
//    - alu_op 01 -> 1111 (equality).
//    - alu_op 10/11 by funct3:
//      - 000 -> 0010, or 0110 only when alu_op=10 and funct7b5=1.
//      - 111 -> 0000.
//      - 110 -> 0001.
//      - 010 -> 0111.
//      - any other funct3 -> 0010.
//    - 1100 (NOR) is never generated.
//  - Stall with out_ready=0: all outputs hold. A held instruction is never duplicated or dropped.
// CONFIGURATION
//  EX_FORWARD_EN defined: forwarding as described above. hazard covers the load-use case only.
//  EX_FORWARD_EN undefined:
//    - fwd() always returns the register-file data.
//    - hazard is extended to any nonzero rs match with exmem_reg_write&exmem_rd or memwb_reg_write&memwb_rd.
// STRUCTURE
//  - Package ex_pkg holds:
//    - ALU_Sel localparams: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100, ALU_EQ=4'b1111.
//    - alu_op encodings.
//  - One combinational sub-module, alu_ctrl_dec: (alu_op, funct3, funct7b5) -> ALU_Sel.
//  - Forwarding muxes and hazard logic stay inline.
// TESTING
//  - Directed scenarios:
//    1. reset=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, A_in=0.
//    2. add x3,x1,x2 with rs1_data=5, rs2_data=7, alu_op=10 -> next cycle A_in=5, B_in=7, ALU_Sel=0010.
//    3. sub with exmem_rd=1, exmem_result=0x10, memwb_rd=1, memwb_result=0x20 -> A_in=0x10 (EX/MEM wins), ALU_Sel=0110.
//    4. rs1=0 with exmem_rd=0, reg_write=1, exmem_result=0xFF -> A_in equals the register-file data, not 0xFF.
//    5. exmem_mem_read=1 and exmem_rd=rs2=4 -> out_valid=0 and in_ready=0. Drop exmem_mem_read the next cycle -> out_valid=1 with the forwarded value.
//    6. out_ready=0 for 3 cycles, then flush=1 -> outputs held for all 3 cycles, then out_valid=0 the cycle after flush.
//  - Run the full suite with and without EX_FORWARD_EN.
//    Without it, scenario 3 must stall until memwb_reg_write deasserts, then present A_in equal to the register-file data.

Source files
------------

// File: rtl/ex_pkg.sv
// -----------------------------------------------------------------------------
// ex_pkg
//   Shared definitions for the decode/execute boundary:
//   - ALU_Sel encodings understood by the 32-bit ALU.
//   - alu_op encodings produced by the main decoder.
// -----------------------------------------------------------------------------
package ex_pkg;

   // ALU_Sel encodings
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;   // supported by the ALU, never issued here
   localparam logic [3:0] ALU_EQ  = 4'b1111;

   // Main-decoder alu_op classes
   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,   // address generation (loads/stores)
      ALU_OP_EQ    = 2'b01,   // branch compare
      ALU_OP_RTYPE = 2'b10,   // register-register ALU
      ALU_OP_ITYPE = 2'b11    // register-immediate ALU
   } alu_op_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// -----------------------------------------------------------------------------
// alu_ctrl_dec
//   Combinational ALU control decoder: maps the main-decoder class plus the
//   instruction's funct3 / bit 30 onto the 4-bit ALU_Sel.
// Ports
//   alu_op    in   alu_op_e  operation class from the main decoder
//   funct3    in   3         instruction funct3
//   funct7b5  in   1         instruction bit 30 (SUB vs ADD for R-type)
//   alu_sel   out  4         ALU operation select
// -----------------------------------------------------------------------------
module alu_ctrl_dec
   import ex_pkg::*;
(
   input  alu_op_e    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [3:0] alu_sel
);

   always_comb begin
      // NOTE: default assignment first so every path drives alu_sel and no latch is inferred.
      alu_sel = ALU_ADD;
      case (alu_op)
         ALU_OP_ADD: alu_sel = ALU_ADD;
         ALU_OP_EQ:  alu_sel = ALU_EQ;
         default: begin
            case (funct3)
               // Bit 30 only means SUB for register-register ops; for ADDI it is immediate bits.
               3'b000:  alu_sel = ((alu_op == ALU_OP_RTYPE) && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b111:  alu_sel = ALU_AND;
               3'b110:  alu_sel = ALU_OR;
               3'b010:  alu_sel = ALU_SLT;
               default: alu_sel = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/id_ex_issue.sv
// -----------------------------------------------------------------------------
// id_ex_issue
//   Decode/execute boundary stage directly upstream of the 32-bit ALU.
//   Holds one decoded instruction, resolves RAW hazards by forwarding or by
//   stalling, and presents A_in / B_in / ALU_Sel plus memory and writeback
//   control to EX/MEM over a valid/ready handshake.
//
// Configuration macro: EX_FORWARD_EN
//   defined   : EX/MEM and MEM/WB results are forwarded; only load-use stalls.
//   undefined : operands always come from the register file; any pending
//               write to a nonzero source register stalls the stage.
//
// Ports
//   clk, reset                    clock (rising edge), synchronous active-high reset
//   flush                         kill the held instruction (branch taken)
//   in_valid / in_ready           decode handshake
//   in_pc, in_rs1, in_rs2, in_rd  instruction PC and register indices
//   in_rs1_data, in_rs2_data      register-file read data
//   in_imm                        sign-extended immediate
//   in_alu_op, in_funct3, in_funct7b5, in_alu_src   ALU control inputs
//   in_reg_write, in_mem_read, in_mem_write          downstream control bits
//   exmem_* / memwb_*             downstream destinations, enables and results
//   out_valid / out_ready         EX/MEM handshake
//   A_in, B_in, ALU_Sel           ALU operands and operation select
//   store_data                    forwarded rs2 value for stores
//   out_pc, out_rd, out_reg_write, out_mem_read, out_mem_write  registered copies
// -----------------------------------------------------------------------------
module id_ex_issue
   import ex_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int PC_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   // Decode side
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [REG_AW-1:0] in_rs1,
   input  logic [REG_AW-1:0] in_rs2,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [1:0]        in_alu_op,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7b5,
   input  logic              in_alu_src,
   input  logic              in_reg_write,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   // Downstream stage state
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic              exmem_reg_write,
   input  logic              memwb_reg_write,
   input  logic              exmem_mem_read,
   input  logic [XLEN-1:0]   exmem_result,
   input  logic [XLEN-1:0]   memwb_result,
   // Execute side
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   A_in,
   output logic [XLEN-1:0]   B_in,
   output logic [3:0]        ALU_Sel,
   output logic [XLEN-1:0]   store_data,
   output logic [PC_W-1:0]   out_pc,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_reg_write,
   output logic              out_mem_read,
   output logic              out_mem_write
);

   // Held instruction
   logic              valid_q;
   logic [PC_W-1:0]   pc_q;
   logic [REG_AW-1:0] rs1_q;
   logic [REG_AW-1:0] rs2_q;
   logic [REG_AW-1:0] rd_q;
   logic [XLEN-1:0]   rs1_data_q;
   logic [XLEN-1:0]   rs2_data_q;
   logic [XLEN-1:0]   imm_q;
   alu_op_e           alu_op_q;
   logic [2:0]        funct3_q;
   logic              funct7b5_q;
   logic              alu_src_q;
   logic              reg_write_q;
   logic              mem_read_q;
   logic              mem_write_q;

   logic              hazard;
   logic              load_use;
   logic              capture;
   logic [XLEN-1:0]   rs1_fwd;
   logic [XLEN-1:0]   rs2_fwd;

   // A destination only matters when it is nonzero and names the source.
   function automatic logic dep(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
      return (dst != '0) && (dst == src);
   endfunction

   // A load in EX/MEM has no data yet, so a dependent instruction must wait.
   assign load_use = exmem_mem_read & (dep(rs1_q, exmem_rd) | dep(rs2_q, exmem_rd));

`ifdef EX_FORWARD_EN
   // Youngest producer (EX/MEM) wins over MEM/WB.
   function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] src,
                                           input logic [XLEN-1:0]   rf_data);
      if (exmem_reg_write && dep(src, exmem_rd)) return exmem_result;
      if (memwb_reg_write && dep(src, memwb_rd)) return memwb_result;
      return rf_data;
   endfunction

   always_comb begin
      rs1_fwd = fwd(rs1_q, rs1_data_q);
      rs2_fwd = fwd(rs2_q, rs2_data_q);
   end

   assign hazard = valid_q & load_use;
`else
   logic dep_pending;
   logic unused_fwd_data;

   assign rs1_fwd = rs1_data_q;
   assign rs2_fwd = rs2_data_q;

   // Without bypass paths, wait until every in-flight write to a source has retired.
   assign dep_pending = (exmem_reg_write & (dep(rs1_q, exmem_rd) | dep(rs2_q, exmem_rd)))
                      | (memwb_reg_write & (dep(rs1_q, memwb_rd) | dep(rs2_q, memwb_rd)));
   assign hazard      = valid_q & (load_use | dep_pending);

   assign unused_fwd_data = ^{exmem_result, memwb_result};
`endif

   // Handshake
   assign out_valid = valid_q & ~hazard;
   assign in_ready  = ~valid_q | (out_ready & ~hazard);
   assign capture   = in_valid & in_ready & ~flush;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         // NOTE: the datapath fields are reset too, so the ALU sees defined zero operands after reset.
         valid_q     <= 1'b0;
         pc_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         alu_op_q    <= ALU_OP_ADD;
         funct3_q    <= '0;
         funct7b5_q  <= 1'b0;
         alu_src_q   <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (capture) begin
         valid_q     <= 1'b1;
         pc_q        <= in_pc;
         rs1_q       <= in_rs1;
         rs2_q       <= in_rs2;
         rd_q        <= in_rd;
         rs1_data_q  <= in_rs1_data;
         rs2_data_q  <= in_rs2_data;
         imm_q       <= in_imm;
         alu_op_q    <= alu_op_e'(in_alu_op);
         funct3_q    <= in_funct3;
         funct7b5_q  <= in_funct7b5;
         alu_src_q   <= in_alu_src;
         reg_write_q <= in_reg_write;
         mem_read_q  <= in_mem_read;
         mem_write_q <= in_mem_write;
      end else if (out_valid && out_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Operands
   assign A_in       = rs1_fwd;
   assign store_data = rs2_fwd;
   assign B_in       = alu_src_q ? imm_q : rs2_fwd;

   alu_ctrl_dec u_alu_ctrl_dec (
      .alu_op   (alu_op_q),
      .funct3   (funct3_q),
      .funct7b5 (funct7b5_q),
      .alu_sel  (ALU_Sel)
   );

   // Registered control copies
   assign out_pc        = pc_q;
   assign out_rd        = rd_q;
   assign out_reg_write = reg_write_q;
   assign out_mem_read  = mem_read_q;
   assign out_mem_write = mem_write_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// -----------------------------------------------------------------------------
// tb_id_ex_issue
//   Self-checking bench for id_ex_issue. Inputs change on the falling edge,
//   outputs are compared 1 ns later against a transaction-level model: a queue
//   holding the instruction currently owned by the stage, with operand and
//   stall expectations computed from the hazard/forwarding rules.
//   Compile with or without +define+EX_FORWARD_EN.
// -----------------------------------------------------------------------------
module tb_id_ex_issue;

`ifdef EX_FORWARD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm;
      logic [1:0]  op;
      logic [2:0]  f3;
      logic        f7, src, rw, mr, mw;
   } instr_t;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready;
   logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [1:0]  in_alu_op;
   logic [2:0]  in_funct3;
   logic        in_funct7b5, in_alu_src, in_reg_write, in_mem_read, in_mem_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        exmem_reg_write, memwb_reg_write, exmem_mem_read;
   logic [31:0] exmem_result, memwb_result;
   logic        out_valid, out_ready;
   logic [31:0] A_in, B_in, store_data, out_pc;
   logic [3:0]  ALU_Sel;
   logic [4:0]  out_rd;
   logic        out_reg_write, out_mem_read, out_mem_write;

   always #5 clk = ~clk;

   id_ex_issue dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .in_alu_src(in_alu_src), .in_reg_write(in_reg_write),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
      .exmem_mem_read(exmem_mem_read),
      .exmem_result(exmem_result), .memwb_result(memwb_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .A_in(A_in), .B_in(B_in), .ALU_Sel(ALU_Sel), .store_data(store_data),
      .out_pc(out_pc), .out_rd(out_rd), .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else n_pass++;
   endtask

   // ---------------- reference model ----------------
   instr_t held[$];   // instruction owned by the stage (0 or 1 entries)
   logic   exp_ir, exp_ov;

   function automatic logic [3:0] ref_sel(input instr_t i);
      if (i.op == 2'b00) return 4'b0010;
      if (i.op == 2'b01) return 4'b1111;
      case (i.f3)
         3'b000:  return (i.op == 2'b10 && i.f7) ? 4'b0110 : 4'b0010;
         3'b111:  return 4'b0000;
         3'b110:  return 4'b0001;
         3'b010:  return 4'b0111;
         default: return 4'b0010;
      endcase
   endfunction

   function automatic logic writes_pending(input logic [4:0] r);
      return r != 0 && ((exmem_reg_write && exmem_rd == r) || (memwb_reg_write && memwb_rd == r));
   endfunction

   function automatic logic [31:0] ref_operand(input logic [4:0] r, input logic [31:0] rf);
      if (FWD_ON && r != 0 && exmem_reg_write && exmem_rd == r) return exmem_result;
      if (FWD_ON && r != 0 && memwb_reg_write && memwb_rd == r) return memwb_result;
      return rf;
   endfunction

   function automatic logic ref_stall(input instr_t i);
      logic load_use;
      load_use = exmem_mem_read && exmem_rd != 0 && (exmem_rd == i.rs1 || exmem_rd == i.rs2);
      return load_use || (!FWD_ON && (writes_pending(i.rs1) || writes_pending(i.rs2)));
   endfunction

   task automatic model_check();
      logic   stall;
      instr_t h;
      stall  = held.size() != 0 && ref_stall(held[0]);
      exp_ov = held.size() != 0 && !stall;
      exp_ir = held.size() == 0 || (out_ready && !stall);
      check("out_valid", out_valid, exp_ov);
      check("in_ready", in_ready, exp_ir);
      if (held.size() != 0) begin
         h = held[0];
         check("A_in", A_in, ref_operand(h.rs1, h.d1));
         check("B_in", B_in, h.src ? h.imm : ref_operand(h.rs2, h.d2));
         check("store_data", store_data, ref_operand(h.rs2, h.d2));
         check("ALU_Sel", ALU_Sel, ref_sel(h));
         check("out_pc", out_pc, h.pc);
         check("out_rd", out_rd, h.rd);
         check("out_ctrl", {out_reg_write, out_mem_read, out_mem_write}, {h.rw, h.mr, h.mw});
      end
   endtask

   task automatic model_update();
      instr_t n;
      if (reset || flush) begin
         held.delete();
      end else begin
         if (exp_ov && out_ready) void'(held.pop_front());
         if (in_valid && exp_ir) begin
            n = '{in_pc, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data, in_imm,
                  in_alu_op, in_funct3, in_funct7b5, in_alu_src,
                  in_reg_write, in_mem_read, in_mem_write};
            held.push_back(n);
         end
      end
   endtask

   // Called at a falling edge: compare, advance one clock, return at next falling edge.
   task automatic cycle();
      #1 model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic quiet();
      flush = 0; in_valid = 0; out_ready = 1;
      exmem_rd = 0; memwb_rd = 0; exmem_reg_write = 0; memwb_reg_write = 0;
      exmem_mem_read = 0; exmem_result = 0; memwb_result = 0;
   endtask

   function automatic instr_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [1:0] op, input logic [2:0] f3, input logic f7);
      instr_t i;
      i = '{$urandom, rs1, rs2, 5'd3, d1, d2, $urandom, op, f3, f7, 1'b0, 1'b1, 1'b0, 1'b0};
      return i;
   endfunction

   task automatic apply(input instr_t i);
      in_valid = 1;
      in_pc = i.pc; in_rs1 = i.rs1; in_rs2 = i.rs2; in_rd = i.rd;
      in_rs1_data = i.d1; in_rs2_data = i.d2; in_imm = i.imm;
      in_alu_op = i.op; in_funct3 = i.f3; in_funct7b5 = i.f7; in_alu_src = i.src;
      in_reg_write = i.rw; in_mem_read = i.mr; in_mem_write = i.mw;
   endtask

   function automatic logic [4:0] rnd_reg();
      return ($urandom_range(9) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(3));
   endfunction

   instr_t t;

   initial begin
      quiet();
      t = mk(1, 2, 32'h11, 32'h22, 2'b10, 3'b000, 0);
      apply(t);

      // 1. reset for two cycles with in_valid held high
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst out_valid", out_valid, 1'b0);
      check("rst in_ready", in_ready, 1'b1);
      check("rst A_in", A_in, 32'h0);
      check("rst B_in", B_in, 32'h0);
      check("rst ALU_Sel", ALU_Sel, 4'b0010);
      check("rst store_data", store_data, 32'h0);
      check("rst ctrl", {out_pc, out_rd, out_reg_write, out_mem_read, out_mem_write}, '0);
      cycle();
      reset = 0;
      in_valid = 0;

      // 2. add x3,x1,x2
      t = mk(1, 2, 32'd5, 32'd7, 2'b10, 3'b000, 0);
      apply(t);
      cycle();
      in_valid = 0;
      #1;
      check("add A_in", A_in, 32'd5);
      check("add B_in", B_in, 32'd7);
      check("add ALU_Sel", ALU_Sel, 4'b0010);
      check("add latency", out_valid, 1'b1);
      cycle();

      // 3. sub with both downstream stages writing rs1
      t = mk(1, 2, 32'h99, 32'h3, 2'b10, 3'b000, 1);
      apply(t);
      exmem_rd = 1; exmem_reg_write = 1; exmem_result = 32'h10;
      memwb_rd = 1; memwb_reg_write = 1; memwb_result = 32'h20;
      cycle();
      in_valid = 0;
      #1;
      check("sub ALU_Sel", ALU_Sel, 4'b0110);
`ifdef EX_FORWARD_EN
      check("sub exmem wins", A_in, 32'h10);
      check("sub out_valid", out_valid, 1'b1);
      cycle();
`else
      check("sub stall exmem", out_valid, 1'b0);
      cycle();
      exmem_reg_write = 0;
      #1 check("sub stall memwb", out_valid, 1'b0);
      cycle();
      memwb_reg_write = 0;
      #1;
      check("sub release", out_valid, 1'b1);
      check("sub rf A_in", A_in, 32'h99);
      cycle();
`endif
      quiet();
      cycle();

      // 4. rs1 = x0 never forwarded
      t = mk(0, 5, 32'h33, 32'h55, 2'b11, 3'b110, 0);
      apply(t);
      exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hFF;
      memwb_rd = 0; memwb_reg_write = 1; memwb_result = 32'hEE;
      cycle();
      in_valid = 0;
      #1;
      check("x0 out_valid", out_valid, 1'b1);
      check("x0 A_in", A_in, 32'h33);
      cycle();
      quiet();

      // 5. load-use on rs2 (store), with a second instruction waiting
      t = mk(3, 4, 32'h30, 32'h44, 2'b00, 3'b010, 0);
      t.mw = 1; t.rw = 0;
      apply(t);
      exmem_mem_read = 1; exmem_rd = 4; exmem_reg_write = 1; exmem_result = 32'h400;
      cycle();
      apply(mk(0, 0, 32'h1, 32'h2, 2'b01, 3'b000, 0));
      #1;
      check("ld-use out_valid", out_valid, 1'b0);
      check("ld-use in_ready", in_ready, 1'b0);
      cycle();
      exmem_mem_read = 0;
`ifdef EX_FORWARD_EN
      #1;
      check("ld-use release", out_valid, 1'b1);
      check("ld-use fwd", store_data, 32'h400);
      cycle();
`else
      #1 check("ld-use still", out_valid, 1'b0);
      cycle();
      exmem_reg_write = 0;
      #1;
      check("ld-use release", out_valid, 1'b1);
      check("ld-use rf", store_data, 32'h44);
      cycle();
`endif
      in_valid = 0;
      cycle();
      cycle();
      quiet();

      // 6. stall three cycles, then flush
      t = mk(6, 7, 32'h600, 32'h700, 2'b11, 3'b111, 0);
      t.src = 1; t.imm = 32'h123;
      apply(t);
      cycle();
      in_valid = 0;
      out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("hold out_valid", out_valid, 1'b1);
         check("hold A_in", A_in, 32'h600);
         check("hold B_in", B_in, 32'h123);
         check("hold store_data", store_data, 32'h700);
         check("hold ALU_Sel", ALU_Sel, 4'b0000);
         cycle();
      end
      flush = 1; out_ready = 1;
      apply(mk(1, 1, 32'h9, 32'h9, 2'b10, 3'b000, 0));
      cycle();
      flush = 0; in_valid = 0;
      #1 check("flush kill", out_valid, 1'b0);
      cycle();

      // Randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(99) == 0);
         flush = ($urandom_range(19) == 0);
         out_ready = ($urandom_range(9) < 7);
         t = mk(rnd_reg(), rnd_reg(), $urandom, $urandom, 2'($urandom_range(3)),
                3'($urandom_range(7)), 1'($urandom_range(1)));
         t.rd = rnd_reg(); t.src = 1'($urandom_range(1));
         t.rw = 1'($urandom_range(1)); t.mr = 1'($urandom_range(1)); t.mw = 1'($urandom_range(1));
         apply(t);
         in_valid = ($urandom_range(9) < 7);
         exmem_rd = rnd_reg(); memwb_rd = rnd_reg();
         exmem_reg_write = 1'($urandom_range(1));
         memwb_reg_write = 1'($urandom_range(1));
         exmem_mem_read = ($urandom_range(3) == 0);
         exmem_result = $urandom; memwb_result = $urandom;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
